// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package instruction_fetch_unit_pkg;

  localparam int                 INSTR_W = 32;
  localparam logic [31:0]        PC_INC  = 32'd4;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0;

  typedef enum logic [1:0] {
    IFU_STATE_BOOT   = 2'd0,
    IFU_STATE_RUN    = 2'd1,
    IFU_STATE_SQUASH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Small prefetch FIFO of {instruction, PC+4} pairs with synchronous clear.
// The head entry is presented combinationally; the caller gates it with count != 0.
module ifu_prefetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues reads to a 1-cycle imem, buffers {instr, PC+4} for IF/ID.
// Optional IFU_PERF_CNT_EN adds fetch_count / squash_count performance counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instructionOut,
  output logic [31:0]        PCPlus4Out
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        squash_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state_q;
  ifu_state_e    state_d;
  logic [31:0]   pc_q;
  logic [31:0]   inflight_addr_q;
  logic          inflight_q;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid & id_ready;
  // The response landing in a redirect cycle belongs to the old path and is dropped.
  assign push        = inflight_q & ~redirect_valid;
  assign push_data   = '{instr: imem_rdata, pc4: inflight_addr_q + PC_INC};
  // Credits: entries held plus the read in flight, minus the one leaving this cycle.
  assign occupancy   = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFU_STATE_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IFU_STATE_BOOT: begin
        state_d = IFU_STATE_RUN;
      end
      IFU_STATE_RUN, IFU_STATE_SQUASH: begin
        state_d = IFU_STATE_RUN;
        issue   = (occupancy < (CW+1)'(FIFO_DEPTH));
      end
      default: begin
        state_d = IFU_STATE_BOOT;
      end
    endcase
    if (redirect_valid) begin
      state_d = IFU_STATE_SQUASH;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= 32'h0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= pc_q;
      end
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (issue) begin
        pc_q <= pc_q + PC_INC;
      end
    end
  end

  ifu_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign imem_en        = issue;
  assign imem_addr      = pc_q;
  assign instructionOut = fetch_valid ? head.instr : NOP;
  assign PCPlus4Out     = fetch_valid ? head.pc4   : 32'h0;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= 32'h0;
      squash_count <= 32'h0;
    end else begin
      if (push) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (inflight_q && redirect_valid) begin
        squash_count <= squash_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed timing scenarios plus a random
// stream, checked by an in-order program-counter model of what IF/ID should receive.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        fetch_valid;
  logic [31:0] instructionOut;
  logic [31:0] PCPlus4Out;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
  logic [31:0] squash_before;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the address IF/ID must receive next, in program order.
  logic [31:0] exp_pc;
  logic        prev_stall;
  logic [31:0] held_pc4;
  logic [31:0] held_instr;

  logic        s_valid;
  logic        s_en;
  logic [31:0] s_addr;
  logic [31:0] s_pc4;
  logic [31:0] s_instr;
  logic        last_en;
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .fetch_valid    (fetch_valid),
    .instructionOut (instructionOut),
    .PCPlus4Out     (PCPlus4Out)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .squash_count   (squash_count)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, run the stream model, answer imem.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    s_valid = fetch_valid;
    s_en    = imem_en;
    s_addr  = imem_addr;
    s_pc4   = PCPlus4Out;
    s_instr = instructionOut;
    if (rst) begin
      exp_pc     = 32'h0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", {31'b0, s_valid}, 32'd1);
        checkOutput("stall_pc4", s_pc4, held_pc4);
        checkOutput("stall_instr", s_instr, held_instr);
      end
      if (s_valid && rdy) begin
        checkOutput("pc4", s_pc4, exp_pc + 32'd4);
        checkOutput("instr", s_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      prev_stall = s_valid && !rdy && !redir;
      held_pc4   = s_pc4;
      held_instr = s_instr;
      if (redir) begin
        exp_pc = rpc & ~32'h3;
      end
    end
    last_en   = imem_en;
    last_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = last_en ? memf(last_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    int waited;
    rst            = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'h0;
    exp_pc         = 32'h0;
    prev_stall     = 1'b0;
    held_pc4       = 32'h0;
    held_instr     = 32'h0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    rst = 1'b0;

    // Scenario 1: boot timing and full-throughput stream.
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("boot_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("boot_en", {31'b0, s_en}, 32'd0);
    checkOutput("boot_pc4", s_pc4, 32'h0);
    checkOutput("boot_instr", s_instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("boot_fetch_count", fetch_count, 32'h0);
    checkOutput("boot_squash_count", squash_count, 32'h0);
`endif
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("first_issue_en", {31'b0, s_en}, 32'd1);
    checkOutput("first_issue_addr", s_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("cycle2_valid", {31'b0, s_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("cycle3_valid", {31'b0, s_valid}, 32'd1);
    checkOutput("cycle3_pc4", s_pc4, 32'h4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stream_valid", {31'b0, s_valid}, 32'd1);
    end

    // Scenario 2: back-pressure freezes outputs and halts issue; release resumes gaplessly.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("backpressure_valid", {31'b0, s_valid}, 32'd1);
      checkOutput("backpressure_en", {31'b0, s_en}, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("release_valid", {31'b0, s_valid}, 32'd1);
    end

    // Scenario 3: single redirect mid-stream.
`ifdef IFU_PERF_CNT_EN
    squash_before = squash_count;
`endif
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("redir_en", {31'b0, s_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_n1_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("redir_n1_en", {31'b0, s_en}, 32'd1);
    checkOutput("redir_n1_addr", s_addr, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_n2_valid", {31'b0, s_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_n3_valid", {31'b0, s_valid}, 32'd1);
    checkOutput("redir_n3_pc4", s_pc4, 32'h104);
`ifdef IFU_PERF_CNT_EN
    checkOutput("squash_count_inc", squash_count, squash_before + 32'd1);
`endif

    // Scenario 4: back-to-back redirects; only the second target stream appears.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b1, 32'h80);
    checkOutput("redir2_en", {31'b0, s_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir2_addr", s_addr, 32'h80);
    checkOutput("redir2_m1_valid", {31'b0, s_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir2_m2_valid", {31'b0, s_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir2_m3_pc4", s_pc4, 32'h84);

    // Scenario 5: target alignment and PC wrap at 2^32.
    applyStimulus(1'b1, 1'b1, 32'h103);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align_addr", s_addr, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_first_addr", s_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_next_en", {31'b0, s_en}, 32'd1);
    checkOutput("wrap_next_addr", s_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc4", s_pc4, 32'h0);

    // Scenario 6: reset with a full FIFO discards everything.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("full_valid", {31'b0, s_valid}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rst_valid", {31'b0, s_valid}, 32'd0);
    checkOutput("rst_en", {31'b0, s_en}, 32'd0);
    checkOutput("rst_pc4", s_pc4, 32'h0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("rst_fetch_count", fetch_count, 32'h0);
    checkOutput("rst_squash_count", squash_count, 32'h0);
`endif
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rst_restart_pc4", s_pc4, 32'h4);

    // Random traffic: stalls and redirects to arbitrary (possibly unaligned) targets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end

    // The stream must come back within a bounded number of cycles once unblocked.
    waited = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      waited++;
    end while (!s_valid && waited < 6);
    checkOutput("liveness_valid", {31'b0, s_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
